keypad_scan_fsm: RTL
====================

// Module: keypad_scan_fsm
// PURPOSE
//   Column-scans the 4x4 matrix keypad, synchronizes and debounces the row sense lines, and produces a clean
//   key_code/key_valid pair for keypad_controller. key_valid is a level: high while one debounced key is held.
//   Sits between the keypad pins and keypad_controller in the top level; runs on the 3 MHz system clock.
// PARAMETERS
//   SCAN_CYCLES      3000   clock cycles each column is driven (1 ms at 3 MHz); the rows are sampled on the last cycle
//   DEBOUNCE_CYCLES  60000  consecutive stable cycles required to accept a press or a release (20 ms)
// PORTS
//   clk        in   1  system clock, 3 MHz
//   rst_n      in   1  asynchronous active-low reset
//   row_n      in   4  keypad rows, active-low, pulled up, asynchronous to clk
//   col_n      out  4  column drive, active-low, exactly one bit low at all times
//   key_code   out  4  hex value of the held key
//   key_valid  out  1  high while a debounced key is held
// BEHAVIOUR
//   - Input sync: row_n passes through a 2-flop synchronizer (row_s). All decisions use row_s.
//     This adds 2 cycles of latency on every row edge.
//   - Reset (async, immediate): state=SCAN, col_idx=0, col_n=4'b1110, key_valid=0, key_code=4'h0.
//     All counters and latched row/col are cleared.
//   - SCAN:
//     - col_n = ~(1<<col_idx).
//     - scan_cnt counts 0..SCAN_CYCLES-1. When scan_cnt reaches SCAN_CYCLES-1, row_s is sampled:
//       - Exactly one bit low: latch row/col, go to DEB_PRESS, deb_cnt=0, column frozen.
//       - Zero bits low, or more than one bit low: col_idx <= col_idx+1 (wraps 3->0), scan_cnt=0.
//   - DEB_PRESS:
//     - col_n stays frozen.
//     - If the latched row_s bit is low, deb_cnt increments. If it is high, go to SCAN, advance the column, scan_cnt=0.
//     - When deb_cnt reaches DEBOUNCE_CYCLES-1 with the row still low, go to HELD. On that same edge,
//       key_valid<=1 and key_code<=KEYMAP[row][col].
//     - key_valid rises exactly DEBOUNCE_CYCLES cycles after entering DEB_PRESS.
//   - HELD:
//     - key_valid=1, key_code and col_n are frozen.
//     - Other keys, including other rows in the same column, are ignored.
//     - When the latched row_s bit goes high, go to DEB_RELEASE with deb_cnt=0.
//   - DEB_RELEASE:
//     - key_valid stays 1.
//     - If the latched row_s bit is low again, return to HELD (bounce).
//     - Otherwise deb_cnt increments. When it reaches DEBOUNCE_CYCLES-1, go to SCAN:
//       key_valid<=0, key_code holds its last value, column advances, scan_cnt=0.
//   - Key map (row r, col c):
//     - r0: 1 2 3 A
//     - r1: 4 5 6 B
//     - r2: 7 8 9 C
//     - r3: E 0 F D
//   - Widths:
//     - scan_cnt is $clog2(SCAN_CYCLES) bits; deb_cnt is $clog2(DEBOUNCE_CYCLES) bits.
//     - Neither counter wraps inside its state.
//   - All outputs are registered; no combinational path from row_n to any output.
// STRUCTURE
//   - keypad_pkg holds:
//     - state enum {SCAN, DEB_PRESS, HELD, DEB_RELEASE}
//     - KEYMAP as logic [3:0] [4][4]
//     - helper function onehot0_low(row) for the single-key check
//   - One sub-module, sync_2ff (parameterized width), used for row_n.
//   - The FSM, counters and column ring stay in keypad_scan_fsm.
// TESTING
//   - Bench uses SCAN_CYCLES=4, DEBOUNCE_CYCLES=8.
//   - Keypad model: row_n[r] = ~|(pressed[r] & ~col_n).
//   - Scenario 1, reset, no keys:
//     - key_valid=0, key_code=0, col_n=1110.
//     - col_n then steps 1110->1101->1011->0111->1110, every 4 cycles.
//   - Scenario 2, press r1c2 ('6') and hold stable:
//     - key_valid rises, key_code=4'h6, col_n frozen at 1011.
//     - Release: key_valid falls 8+2 cycles after the row goes high; scanning resumes at col 3.
//   - Scenario 3, press bounce on r0c0 ('1'): row toggles every 3 cycles for 30 cycles, then stays stable.
//     - Exactly one key_valid rising edge, with key_code=4'h1; no pulse during the bounce.
//   - Scenario 4, release bounce on '1': row toggles high/low every 3 cycles.
//     - key_valid stays 1 throughout and drops only after 8 stable high cycles.
//   - Scenario 5, hold '5', then also press 'A' (other column) and '8' (same column).
//     - key_code stays 4'h5, key_valid stays 1. After '5' is released, 'A' or '8' is detected next.
//   - Scenario 6, reset in HELD: assert rst_n=0 between clock edges.
//     - key_valid=0 and col_n=1110 immediately (asynchronously).
//     - After rst_n=1 with the key still held, the key is re-detected via DEB_PRESS.

Source files
------------

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types, key map and row-decode helpers for the keypad scanner
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN        = 2'd0,
      DEB_PRESS   = 2'd1,
      HELD        = 2'd2,
      DEB_RELEASE = 2'd3
   } state_t;

   // Indexed [row][col]; rows and columns both count from 0.
   localparam logic [3:0] KEYMAP [4][4] = '{
      '{4'h1, 4'h2, 4'h3, 4'hA},
      '{4'h4, 4'h5, 4'h6, 4'hB},
      '{4'h7, 4'h8, 4'h9, 4'hC},
      '{4'hE, 4'h0, 4'hF, 4'hD}
   };

   function automatic logic onehot0_low(input logic [3:0] row);
      return $onehot(~row);
   endfunction

   function automatic logic [1:0] low_index(input logic [3:0] row);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (!row[i]) idx = i[1:0];
      end
      return idx;
   endfunction

endpackage

// File: rtl/keypad_scan_fsm_if.sv
// rtl/keypad_scan_fsm_if.sv - keypad pin and decoded-key bundle
interface keypad_scan_fsm_if;
   logic [3:0] row_n;
   logic [3:0] col_n;
   logic [3:0] key_code;
   logic       key_valid;

   modport master (input row_n, output col_n, output key_code, output key_valid);
   modport slave  (output row_n, input col_n, input key_code, input key_valid);
endinterface

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer with configurable width and reset value
module sync_2ff #(
   parameter int              WIDTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/keypad_scan_fsm.sv
// rtl/keypad_scan_fsm.sv - 4x4 keypad column scanner with press/release debounce
module keypad_scan_fsm
   import keypad_pkg::*;
#(
   parameter int SCAN_CYCLES     = 3000,
   parameter int DEBOUNCE_CYCLES = 60000
) (
   input  logic               clk,
   input  logic               rst_n,
   keypad_scan_fsm_if.master  kp
);

   localparam int SCAN_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
   localparam int DEB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYCLES - 1);
   localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);

   state_t            state;
   logic [1:0]        col_idx;
   logic [3:0]        col_n_q;
   logic [1:0]        row_lat;
   logic [SCAN_W-1:0] scan_cnt;
   logic [DEB_W-1:0]  deb_cnt;
   logic [3:0]        key_code_q;
   logic              key_valid_q;
   logic [3:0]        row_s;

   sync_2ff #(
      .WIDTH     (4),
      .RESET_VAL (4'hF)
   ) u_row_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (kp.row_n),
      .q     (row_s)
   );

   // col_n_q is a rotating one-cold ring kept in step with col_idx.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= SCAN;
         col_idx     <= 2'd0;
         col_n_q     <= 4'b1110;
         row_lat     <= 2'd0;
         scan_cnt    <= '0;
         deb_cnt     <= '0;
         key_code_q  <= 4'h0;
         key_valid_q <= 1'b0;
      end else begin
         case (state)
            SCAN: begin
               if (scan_cnt == SCAN_LAST) begin
                  scan_cnt <= '0;
                  if (onehot0_low(row_s)) begin
                     row_lat <= low_index(row_s);
                     deb_cnt <= '0;
                     state   <= DEB_PRESS;
                  end else begin
                     col_idx <= col_idx + 2'd1;
                     col_n_q <= {col_n_q[2:0], col_n_q[3]};
                  end
               end else begin
                  scan_cnt <= scan_cnt + SCAN_W'(1);
               end
            end

            DEB_PRESS: begin
               if (row_s[row_lat]) begin
                  state    <= SCAN;
                  scan_cnt <= '0;
                  col_idx  <= col_idx + 2'd1;
                  col_n_q  <= {col_n_q[2:0], col_n_q[3]};
               end else if (deb_cnt == DEB_LAST) begin
                  state       <= HELD;
                  key_valid_q <= 1'b1;
                  key_code_q  <= KEYMAP[row_lat][col_idx];
               end else begin
                  deb_cnt <= deb_cnt + DEB_W'(1);
               end
            end

            // Only the latched row matters here; any other key stays invisible.
            HELD: begin
               if (row_s[row_lat]) begin
                  state   <= DEB_RELEASE;
                  deb_cnt <= '0;
               end
            end

            DEB_RELEASE: begin
               if (!row_s[row_lat]) begin
                  state <= HELD;
               end else if (deb_cnt == DEB_LAST) begin
                  state       <= SCAN;
                  key_valid_q <= 1'b0;
                  scan_cnt    <= '0;
                  col_idx     <= col_idx + 2'd1;
                  col_n_q     <= {col_n_q[2:0], col_n_q[3]};
               end else begin
                  deb_cnt <= deb_cnt + DEB_W'(1);
               end
            end

            default: state <= SCAN;
         endcase
      end
   end

   assign kp.col_n     = col_n_q;
   assign kp.key_code  = key_code_q;
   assign kp.key_valid = key_valid_q;

endmodule
